// File: rtl/axi_pkg.sv
// AXI4 encodings and the bridge state type shared by AXI-facing blocks.
package axi_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP,
    RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/config.sv
// Core-wide configuration constants shared by the LSU-side blocks.
package config_pkg;
  localparam int CPU_WIDTH = 64;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
endpackage

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding LSU-to-AXI4 bridge: one load or store becomes one
// single-beat AXI transaction, completed by a one-cycle mem_ready pulse.
module lsu_axi_bridge
  import config_pkg::*;
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic                 mem_we,
  input  logic [63:0]          mem_addr,
  input  logic [1:0]           mem_size,
  input  logic [CPU_WIDTH-1:0] mem_wdata,
  input  logic [7:0]           wmask,
  output logic [CPU_WIDTH-1:0] mem_rdata,
  output logic [1:0]           mem_resp,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [ADDR_W-1:0]    awaddr,
  output logic [ID_W-1:0]      awid,
  output logic [7:0]           awlen,
  output logic [2:0]           awsize,
  output logic [1:0]           awburst,
  output logic                 wvalid,
  input  logic                 wready,
  output logic [CPU_WIDTH-1:0] wdata,
  output logic [7:0]           wstrb,
  output logic                 wlast,
  input  logic                 bvalid,
  output logic                 bready,
  input  logic [1:0]           bresp,
  input  logic [ID_W-1:0]      bid,
  output logic                 arvalid,
  input  logic                 arready,
  output logic [ADDR_W-1:0]    araddr,
  output logic [ID_W-1:0]      arid,
  output logic [7:0]           arlen,
  output logic [2:0]           arsize,
  output logic [1:0]           arburst,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic [CPU_WIDTH-1:0] rdata,
  input  logic [1:0]           rresp,
  input  logic                 rlast,
  input  logic [ID_W-1:0]      rid
);

  state_t               state_q, state_d;
  logic                 we_q;
  logic [63:0]          addr_q;
  logic [1:0]           size_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [7:0]           mask_q;
  logic                 aw_done_q, w_done_q;
  logic [CPU_WIDTH-1:0] rdata_q;
  logic [1:0]           resp_q;
  logic                 aw_fire, w_fire;
  logic                 unused_ok;

  // Right-align a load so the byte at the request address lands in [7:0].
  function automatic logic [CPU_WIDTH-1:0] align_load(input logic [CPU_WIDTH-1:0] data,
                                                      input logic [2:0] offset);
    return data >> {offset, 3'b000};
  endfunction

  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  assign awaddr  = addr_q[ADDR_W-1:0];
  assign araddr  = addr_q[ADDR_W-1:0];
  assign awid    = '0;
  assign arid    = '0;
  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign arsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign arburst = BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = mask_q;
  assign wlast   = 1'b1;

  assign mem_rdata = rdata_q;
  assign mem_resp  = resp_q;

  // Response IDs, rlast and the address bits above ADDR_W carry no information here.
  assign unused_ok = ^{rlast, rid, bid, addr_q, we_q};

  always_comb begin
    state_d   = state_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      IDLE: if (mem_valid) state_d = mem_we ? WR_ADDR : RD_ADDR;
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_d = RESP;
      end
      WR_ADDR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if ((aw_done_q || awready) && (w_done_q || wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = RESP;
      end
      RESP: begin
        mem_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      if (state_q != WR_ADDR) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_fire) aw_done_q <= 1'b1;
        if (w_fire)  w_done_q  <= 1'b1;
      end
      if (state_q == RD_DATA && rvalid) begin
        rdata_q <= align_load(rdata, addr_q[2:0]);
        resp_q  <= rresp;
      end
      if (state_q == WR_RESP && bvalid) begin
        rdata_q <= '0;
        resp_q  <= bresp;
      end
    end
  end

  // Request payload: captured once per request, held stable for the whole transaction.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && mem_valid) begin
      we_q    <= mem_we;
      addr_q  <= mem_addr;
      size_q  <= mem_size;
      wdata_q <= mem_wdata;
      mask_q  <= wmask;
    end
  end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Bench for lsu_axi_bridge: randomized AXI slave with delays, transaction-level
// scoreboard, per-cycle protocol model, and directed literal scenarios.
module tb_lsu_axi_bridge;
  import config_pkg::*;
  import axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic mem_valid, mem_ready, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] mem_size, mem_resp;
  logic [7:0] wmask;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [7:0] awlen, arlen, wstrb;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  lsu_axi_bridge #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata), .wmask(wmask),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Slave behaviour for the current transaction.
  int ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [63:0] cur_rdata;
  logic [1:0]  cur_resp;
  bit busy = 1'b0;
  bit unsol_en = 1'b0;

  // Scoreboard of completions and observed handshake counts.
  logic [63:0] exp_rd_q[$];
  logic [1:0]  exp_rs_q[$];
  int n_ar = 0, n_aw = 0, n_w = 0;
  logic [31:0] last_araddr;
  logic [2:0]  last_arsize;
  logic [7:0]  last_wstrb;
  logic        last_wlast;
  logic [63:0] last_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // AXI slave: readies after a programmed delay, responses after the consumer's ready.
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = '0; rresp = '0; rlast = 0; rid = '0; bresp = '0; bid = '0;
    forever begin
      @(posedge i_clk); #2;
      if (!i_rst_n) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        continue;
      end
      rid = ID_W'($urandom); bid = ID_W'($urandom); rlast = 1'($urandom);
      arready = 0;
      if (arvalid) begin if (ar_c >= ar_dly) arready = 1; else ar_c++; end else ar_c = 0;
      awready = 0;
      if (awvalid) begin if (aw_c >= aw_dly) awready = 1; else aw_c++; end else aw_c = 0;
      wready = 0;
      if (wvalid) begin if (w_c >= w_dly) wready = 1; else w_c++; end else w_c = 0;
      rvalid = 0;
      if (rready) begin
        if (r_c >= r_dly) begin rvalid = 1; rdata = cur_rdata; rresp = cur_resp; end
        else r_c++;
      end else r_c = 0;
      bvalid = 0;
      if (bready) begin
        if (b_c >= b_dly) begin bvalid = 1; bresp = cur_resp; end
        else b_c++;
      end else b_c = 0;
      if (!busy && unsol_en && $urandom_range(0, 3) == 0) begin
        rvalid = 1; rdata = {$urandom, $urandom}; rresp = 2'($urandom);
        bvalid = 1; bresp = 2'($urandom);
      end
    end
  end

  // Per-cycle protocol model and completion scoreboard.
  initial begin
    int ph;
    bit ld, awh, wh;
    logic [63:0] q_addr, q_wdata;
    logic [1:0]  q_size;
    logic [7:0]  q_mask;
    ph = 0; ld = 0; awh = 0; wh = 0;
    q_addr = '0; q_wdata = '0; q_size = '0; q_mask = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        ph = 0;
        exp_rd_q.delete();
        exp_rs_q.delete();
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, mem_ready}, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_mem_resp", mem_resp, 0);
        continue;
      end
      chk("arvalid", arvalid, ph == 1 && ld);
      chk("awvalid", awvalid, ph == 1 && !ld && !awh);
      chk("wvalid", wvalid, ph == 1 && !ld && !wh);
      chk("rready", rready, ph == 2 && ld);
      chk("bready", bready, ph == 2 && !ld);
      chk("mem_ready", mem_ready, ph == 3);
      if (arvalid) begin
        chk("araddr", araddr, q_addr[31:0]);
        chk("arsize", arsize, {1'b0, q_size});
        chk("ar_fixed", {arlen, arburst, arid}, {8'd0, 2'b01, 4'd0});
        last_araddr = araddr; last_arsize = arsize;
      end
      if (awvalid) begin
        chk("awaddr", awaddr, q_addr[31:0]);
        chk("awsize", awsize, {1'b0, q_size});
        chk("aw_fixed", {awlen, awburst, awid}, {8'd0, 2'b01, 4'd0});
      end
      if (wvalid) begin
        chk("wdata", wdata, q_wdata);
        chk("wstrb", wstrb, q_mask);
        chk("wlast", wlast, 1);
        last_wstrb = wstrb; last_wlast = wlast; last_wdata = wdata;
      end
      if (arvalid && arready) n_ar++;
      if (awvalid && awready) n_aw++;
      if (wvalid && wready) n_w++;
      if (ph == 3) begin
        if (exp_rd_q.size() == 0) chk("sb_unexpected_completion", 1, 0);
        else begin
          chk("mem_rdata", mem_rdata, exp_rd_q.pop_front());
          chk("mem_resp", mem_resp, exp_rs_q.pop_front());
        end
      end
      case (ph)
        0: if (mem_valid) begin
             ld = !mem_we; q_addr = mem_addr; q_size = mem_size;
             q_wdata = mem_wdata; q_mask = wmask; awh = 0; wh = 0; ph = 1;
           end
        1: if (ld) begin
             if (arready) ph = 2;
           end else begin
             if (!awh && awready) awh = 1;
             if (!wh && wready) wh = 1;
             if (awh && wh) ph = 2;
           end
        2: if (ld ? rvalid : bvalid) ph = 3;
        default: ph = 0;
      endcase
    end
  end

  task automatic run_txn(input bit we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wd, input logic [7:0] mk,
                         input int dar, input int dr, input int daw, input int dw, input int db,
                         input logic [63:0] rd, input logic [1:0] rs,
                         output int lat, output logic [63:0] got_rd, output logic [1:0] got_rs);
    int p, exp_lat;
    ar_dly = dar; r_dly = dr; aw_dly = daw; w_dly = dw; b_dly = db;
    cur_rdata = rd; cur_resp = rs;
    exp_rd_q.push_back(we ? 64'h0 : rd >> (8 * (addr % 8)));
    exp_rs_q.push_back(rs);
    exp_lat = we ? 3 + (daw > dw ? daw : dw) + db : 3 + dar + dr;
    @(posedge i_clk); #1;
    busy = 1; mem_valid = 1; mem_we = we; mem_addr = addr; mem_size = size;
    mem_wdata = wd; wmask = mk;
    p = cyc; lat = -1; got_rd = '0; got_rs = '0;
    for (int k = 0; k < 100; k++) begin
      @(posedge i_clk); #1;
      if (mem_ready) begin lat = cyc - p; got_rd = mem_rdata; got_rs = mem_resp; break; end
    end
    mem_valid = 0; busy = 0;
    chk("latency", lat, exp_lat);
    @(posedge i_clk); #1;
    chk("mem_ready_pulse", mem_ready, 0);
  endtask

  initial begin
    int lat, m1, m2, aw0, ar0;
    logic [63:0] grd;
    logic [1:0] grs;
    mem_valid = 0; mem_we = 0; mem_addr = '0; mem_size = '0; mem_wdata = '0; wmask = '0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    cur_rdata = '0; cur_resp = RESP_OKAY;
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1;

    // Aligned doubleword load, arready delayed 2 cycles.
    run_txn(0, 64'h8000_0010, SIZE_D, '0, '0, 2, 0, 0, 0, 0,
            64'h1122334455667788, RESP_OKAY, lat, grd, grs);
    chk("ld_d_data", grd, 64'h1122334455667788);
    chk("ld_d_resp", grs, 2'b00);
    chk("ld_d_lat", lat, 5);

    // Unaligned byte load.
    run_txn(0, 64'h8000_0013, SIZE_B, '0, '0, 0, 0, 0, 0, 0,
            64'h0000_0000_AB00_0000, RESP_EXOKAY, lat, grd, grs);
    chk("lb_data", grd, 64'hAB);
    chk("lb_resp", grs, 2'b01);
    chk("lb_araddr", last_araddr, 32'h8000_0013);
    chk("lb_arsize", last_arsize, 3'd0);

    // Upper-word store, W accepted 3 cycles before AW.
    run_txn(1, 64'h8000_0004, SIZE_W, 64'hDEADBEEF_00000000, 8'hF0, 0, 0, 3, 0, 0,
            64'h5555_5555_5555_5555, RESP_OKAY, lat, grd, grs);
    chk("sw_wstrb", last_wstrb, 8'hF0);
    chk("sw_wlast", last_wlast, 1);
    chk("sw_wdata", last_wdata, 64'hDEADBEEF_00000000);
    chk("sw_rdata", grd, 0);
    chk("sw_lat", lat, 6);

    // Store error response, single AW.
    aw0 = n_aw;
    run_txn(1, 64'h8000_0040, SIZE_D, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 1, 2, 1,
            '0, RESP_SLVERR, lat, grd, grs);
    repeat (4) @(posedge i_clk);
    chk("st_err_resp", grs, 2'b10);
    chk("st_err_aw_count", n_aw - aw0, 1);

    // Reset while waiting for read data.
    ar_dly = 0; r_dly = 30; cur_rdata = 64'hFFFF_0000_FFFF_0000; cur_resp = RESP_OKAY;
    @(posedge i_clk); #1;
    busy = 1; mem_valid = 1; mem_we = 0; mem_addr = 64'h8000_0100; mem_size = SIZE_D;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      if (rready) break;
    end
    chk("rst_mid_pre_rready", rready, 1);
    @(posedge i_clk); #3;
    i_rst_n = 0;
    #1;
    chk("rst_mid_now", {rready, arvalid, mem_ready}, 0);
    mem_valid = 0; busy = 0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1;
    run_txn(0, 64'h8000_0106, SIZE_H, '0, '0, 1, 1, 0, 0, 0,
            64'h1234_5678_9ABC_DEF0, RESP_OKAY, lat, grd, grs);
    chk("rst_mid_after_data", grd, 64'h1234);

    // Unsolicited responses while idle must not be accepted.
    unsol_en = 1;
    repeat (12) @(posedge i_clk);

    // Back-to-back store then load, zero-wait slave.
    aw0 = n_aw; ar0 = n_ar; m1 = -100; m2 = 0;
    ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    cur_rdata = 64'hCAFE_F00D_0BAD_BEEF; cur_resp = RESP_OKAY;
    exp_rd_q.push_back(64'h0); exp_rs_q.push_back(RESP_OKAY);
    exp_rd_q.push_back(64'hCAFE_F00D_0BAD_BEEF); exp_rs_q.push_back(RESP_OKAY);
    @(posedge i_clk); #1;
    busy = 1; mem_valid = 1; mem_we = 1; mem_addr = 64'h8000_0200; mem_size = SIZE_D;
    mem_wdata = 64'hA5A5_A5A5_A5A5_A5A5; wmask = 8'hFF;
    for (int k = 0; k < 50; k++) begin
      @(posedge i_clk); #1;
      if (mem_ready) begin m1 = cyc; break; end
    end
    mem_we = 0; mem_addr = 64'h8000_0208;
    for (int k = 0; k < 50; k++) begin
      @(posedge i_clk); #1;
      if (mem_ready) begin m2 = cyc; break; end
    end
    mem_valid = 0; busy = 0;
    repeat (4) @(posedge i_clk);
    chk("b2b_spacing", m2 - m1, 4);
    chk("b2b_aw_count", n_aw - aw0, 1);
    chk("b2b_ar_count", n_ar - ar0, 1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      bit we;
      logic [1:0] sz;
      we = 1'($urandom);
      sz = 2'($urandom);
      run_txn(we, {$urandom, $urandom}, sz, {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom}, 2'($urandom), lat, grd, grs);
    end
    unsol_en = 0;
    repeat (3) @(posedge i_clk);
    chk("sb_drained", exp_rd_q.size(), 0);
    chk("aw_w_balanced", n_aw, n_w);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_axi_bridge.md
# lsu_axi_bridge

Single-outstanding bridge between the LSU request interface and a 64-bit AXI4 master port.
- Accepts one load or store per request, runs one single-beat AXI transaction (AR/R or AW/W/B), then pulses `mem_ready` with read data and response.
- Sits between the LSU and the AXI interconnect, on the responder side of the LSU's `axi_mem_valid`/`axi_mem_ready` handshake.

## Interface
- `ADDR_W`, default 32: AXI address width; the request address is truncated to this width.
- `ID_W`, default 4: AXI ID width; all IDs are driven to 0.
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `mem_valid`  in  1  LSU request valid; held with stable payload until `mem_ready`
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_we`  in  1  1 = store, 0 = load
- `mem_addr`  in  64  byte address
- `mem_size`  in  2  `SIZE_B`/`SIZE_H`/`SIZE_W`/`SIZE_D`
- `mem_wdata`  in  64  lane-aligned store data
- `wmask`  in  8  byte strobes
- `mem_rdata`  out  64  load data, right-aligned (byte at `mem_addr` in bits [7:0])
- `mem_resp`  out  2  AXI RRESP/BRESP of the transaction
- AW channel: `awvalid` out 1; `awready` in 1; `awaddr` out ADDR_W; `awid` out ID_W; `awlen` out 8; `awsize` out 3; `awburst` out 2
- W channel: `wvalid` out 1; `wready` in 1; `wdata` out 64; `wstrb` out 8; `wlast` out 1
- B channel: `bvalid` in 1; `bready` out 1; `bresp` in 2; `bid` in ID_W
- AR channel: `arvalid` out 1; `arready` in 1; `araddr` out ADDR_W; `arid` out ID_W; `arlen` out 8; `arsize` out 3; `arburst` out 2
- R channel: `rvalid` in 1; `rready` out 1; `rdata` in 64; `rresp` in 2; `rlast` in 1; `rid` in ID_W

## Operation
- **Request capture.** In `IDLE`, when `mem_valid` = 1, register `mem_we`, `mem_addr`, `mem_size`, `mem_wdata` and `wmask`. Go to `RD_ADDR` (load) or `WR_ADDR` (store).
- **AXI request fields.** `axlen` = 0; `axburst` = INCR (2'b01); `axsize` = {1'b0, size_q}; `axaddr` = addr_q[ADDR_W-1:0], unaligned passed as-is. `wstrb` = mask_q; `wlast` = 1.
- **`RD_ADDR`.** `arvalid` = 1. On `arready`, go to `RD_DATA`.
- **`RD_DATA`.** `rready` = 1. On `rvalid`, capture `rdata >> (8*addr_q[2:0])` and `rresp`, then go to `RESP`.
- **`WR_ADDR`.** `awvalid` and `wvalid` are each held until their own handshake; `aw_done`/`w_done` flags track each. When both have handshaken (same or different cycles), go to `WR_RESP`.
- **`WR_RESP`.** `bready` = 1. On `bvalid`, capture `bresp`, then go to `RESP`.
- **`RESP`.** `mem_ready` = 1 for exactly one cycle, with `mem_rdata`/`mem_resp` valid. Then go to `IDLE`.
  - Stores return `mem_rdata` = 0.
  - SLVERR/DECERR are passed through unchanged. The bridge never retries.
- **Next request.** A `mem_valid` seen in `IDLE` after `RESP` is a new request; upstream must drop or advance the request in the `mem_ready` cycle.
- **Ignored inputs.** `rlast`, `rid` and `bid` are ignored. An unsolicited `rvalid`/`bvalid` outside its state is not accepted (ready stays 0).

## Timing
- **Reset values.** All `*valid`/`*ready` outputs = 0, `mem_rdata` = 0, `mem_resp` = 0, state = `IDLE`.
- **Reset mid-transaction.** Asynchronous abort to `IDLE`; the AXI slave must be reset alongside.
- **Valid outputs.** All are decoded from registered state only; none combinationally depends on an AXI ready.
- **Minimum load latency.** `mem_valid` at cycle N → `arvalid` at N+1 → (`arready` N+1) `rready` at N+2 → (`rvalid` N+2) `mem_ready` at N+3.
- **Minimum store latency.** Also 3 cycles: `awvalid`/`wvalid` at N+1, `bready` at N+2, `mem_ready` at N+3.
- **Stalls.** Any ready/valid stall extends the matching state cycle for cycle; the payload stays stable.

## Structure
- **Shared package `axi_pkg`:**
  - state enum {`IDLE`, `RD_ADDR`, `RD_DATA`, `WR_ADDR`, `WR_RESP`, `RESP`}
  - `BURST_INCR`
  - `RESP_OKAY`/`EXOKAY`/`SLVERR`/`DECERR`
- **Constants from `config.sv`:** `SIZE_*` and `CPU_WIDTH`.
- **No sub-module.** The read-alignment shifter is inline.

## Test plan
- **Aligned LD.** addr 0x8000_0010, size D; slave returns 0x1122334455667788 OKAY after a 2-cycle `arready` delay → `mem_rdata` = 0x1122334455667788, `mem_resp` = 0, `mem_ready` exactly one cycle at N+5.
- **Unaligned LB.** addr 0x8000_0013, size B; `rdata` = 0x0000_0000_AB00_0000 → `mem_rdata` = 0x...AB in bits [7:0] (0xAB), `arsize` = 0, `araddr` = 0x8000_0013.
- **SW upper word.** addr 0x8000_0004, `wmask` 0xF0, `wdata` 0xDEADBEEF_00000000; `wready` 3 cycles before `awready` → `wstrb` = 0xF0, `wlast` = 1, `bready` only after both handshakes, completion at the `bvalid` cycle +1.
- **Store error.** `bresp` = SLVERR → `mem_resp` = 2'b10, `mem_ready` pulses, state returns to `IDLE`, no second AW issued.
- **Reset mid-transaction.** `i_rst_n` low while in `RD_DATA` → `rready`/`arvalid`/`mem_ready` = 0 immediately; after release, a new LD completes normally.
- **Back-to-back.** SD then LD held on consecutive requests with zero-wait slave → two `mem_ready` pulses 4 cycles apart, no extra AXI transactions.
